// File: rtl/nios_base_ext_pkg.sv
// Shared constants and helpers for the ext_ctrl input-conditioning block.
// Holds the default channel count, synchroniser depth and debounce length,
// plus a constant-foldable clog2 used to size the per-channel counter.
package nios_base_ext_pkg;

    localparam int EXT_WIDTH           = 4;
    localparam int EXT_SYNC_STAGES     = 2;
    localparam int EXT_DEBOUNCE_CYCLES = 16;

    // Ceiling log2; returns 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/nios_base_ext_debounce_chan.sv
// Single-line input conditioner: synchroniser chain, consecutive-sample
// debounce counter and registered edge strobes.
//   clk    - system clock
//   reset  - asynchronous, active-high reset
//   enable - high: filtering runs; low: counter held at 0, level frozen
//   raw    - asynchronous bouncy input line
//   clean  - debounced level
//   rise   - one-cycle strobe when a 0->1 level is accepted
//   fall   - one-cycle strobe when a 1->0 level is accepted
module nios_base_ext_debounce_chan
    import nios_base_ext_pkg::*;
#(
    parameter int SYNC_STAGES     = EXT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = EXT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = (clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   s;

    // Synchroniser runs regardless of enable so the sampled level stays current.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Any sample matching the current level restarts the run, so a new level
    // is only accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (!enable) begin
                cnt_q <= '0;
            end else if (s == clean) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_MAX) begin
                clean <= s;
                cnt_q <= '0;
                rise  <= s;
                fall  <= ~s;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/nios_base_ext_debounce.sv
// Input conditioning stage feeding the ext_ctrl PIO in_port. Each of WIDTH
// raw external lines is synchronised and debounced independently.
//   clk        - system clock
//   reset      - asynchronous, active-high reset
//   enable     - high: filtering active; low: outputs frozen, pulses 0
//   raw_in     - asynchronous external lines
//   clean_out  - debounced levels (to PIO in_port)
//   rise_pulse - one-cycle strobes on accepted 0->1
//   fall_pulse - one-cycle strobes on accepted 1->0
module nios_base_ext_debounce
    import nios_base_ext_pkg::*;
#(
    parameter int WIDTH           = EXT_WIDTH,
    parameter int SYNC_STAGES     = EXT_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = EXT_DEBOUNCE_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] clean_out,
    output logic [WIDTH-1:0] rise_pulse,
    output logic [WIDTH-1:0] fall_pulse
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        nios_base_ext_debounce_chan #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .raw    (raw_in[i]),
            .clean  (clean_out[i]),
            .rise   (rise_pulse[i]),
            .fall   (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_nios_base_ext_debounce.sv
// Self-checking bench for nios_base_ext_debounce: default-parameter instance
// driven from a vector table plus directed sequences, and a second instance
// with DEBOUNCE_CYCLES=1, SYNC_STAGES=3 for the short-filter corner.
module tb_nios_base_ext_debounce;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] raw_in;
    logic [3:0] clean_out;
    logic [3:0] rise_pulse;
    logic [3:0] fall_pulse;

    logic [0:0] raw2;
    logic [0:0] clean2;
    logic [0:0] rise2;
    logic [0:0] fall2;

    int checks;
    int errors;

    logic [3:0] acc_rise;
    logic [3:0] acc_fall;
    logic [3:0] acc_clean;

    nios_base_ext_debounce u_dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .raw_in     (raw_in),
        .clean_out  (clean_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    nios_base_ext_debounce #(
        .WIDTH           (1),
        .SYNC_STAGES     (3),
        .DEBOUNCE_CYCLES (1)
    ) u_dut_fast (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .raw_in     (raw2),
        .clean_out  (clean2),
        .rise_pulse (rise2),
        .fall_pulse (fall2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [3:0] raw;
        logic       en;
        int         n;
        logic [3:0] clean;
        logic [3:0] rise;
        logic [3:0] fall;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance n clocks, sampling 1 time unit after each edge and OR-ing outputs.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            acc_rise  = acc_rise | rise_pulse;
            acc_fall  = acc_fall | fall_pulse;
            acc_clean = acc_clean | clean_out;
        end
    endtask

    task automatic clear_acc();
        acc_rise  = '0;
        acc_fall  = '0;
        acc_clean = '0;
    endtask

    task automatic apply_reset();
        @(posedge clk);
        #1;
        raw_in = '0;
        raw2   = '0;
        enable = 1'b1;
        reset  = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step(20);
    endtask

    initial begin
        int n_rise;
        int rise_at;

        checks = 0;
        errors = 0;
        clear_acc();

        // Clean step on bit 0 (17 cycles quiet, accepted on the 18th edge
        // counting the sampling edge as the first)
        vecs[0]  = '{4'b0000, 1'b1,  2, 4'b0000, 4'b0000, 4'b0000};
        vecs[1]  = '{4'b0001, 1'b1, 17, 4'b0000, 4'b0000, 4'b0000};
        vecs[2]  = '{4'b0001, 1'b1,  1, 4'b0001, 4'b0001, 4'b0000};
        vecs[3]  = '{4'b0001, 1'b1,  1, 4'b0001, 4'b0000, 4'b0000};
        // 15-cycle glitch on bit 1 rejected
        vecs[4]  = '{4'b0011, 1'b1, 15, 4'b0001, 4'b0000, 4'b0000};
        vecs[5]  = '{4'b0001, 1'b1, 20, 4'b0001, 4'b0000, 4'b0000};
        // 16-cycle high on bit 1 accepted, then the low is accepted as a fall
        vecs[6]  = '{4'b0011, 1'b1, 16, 4'b0001, 4'b0000, 4'b0000};
        vecs[7]  = '{4'b0001, 1'b1,  1, 4'b0001, 4'b0000, 4'b0000};
        vecs[8]  = '{4'b0001, 1'b1,  1, 4'b0011, 4'b0010, 4'b0000};
        vecs[9]  = '{4'b0001, 1'b1,  1, 4'b0011, 4'b0000, 4'b0000};
        vecs[10] = '{4'b0001, 1'b1, 14, 4'b0011, 4'b0000, 4'b0000};
        vecs[11] = '{4'b0001, 1'b1,  1, 4'b0001, 4'b0000, 4'b0010};
        vecs[12] = '{4'b0001, 1'b1,  1, 4'b0001, 4'b0000, 4'b0000};
        // Enable freeze, then a full run after re-enable
        vecs[13] = '{4'b1110, 1'b0, 30, 4'b0001, 4'b0000, 4'b0000};
        vecs[14] = '{4'b1110, 1'b1, 15, 4'b0001, 4'b0000, 4'b0000};
        vecs[15] = '{4'b1110, 1'b1,  1, 4'b1110, 4'b1110, 4'b0001};
        vecs[16] = '{4'b1110, 1'b1,  1, 4'b1110, 4'b0000, 4'b0000};

        reset  = 1'b1;
        enable = 1'b1;
        raw_in = '0;
        raw2   = '0;
        #1;
        check("reset_clean", 32'(clean_out), 32'h0);
        check("reset_rise", 32'(rise_pulse), 32'h0);
        check("reset_fall", 32'(fall_pulse), 32'h0);
        check("reset_fast_clean", 32'(clean2), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int v = 0; v < NV; v++) begin
            raw_in = vecs[v].raw;
            enable = vecs[v].en;
            clear_acc();
            step(vecs[v].n);
            check($sformatf("vec%0d_clean", v), 32'(clean_out), 32'(vecs[v].clean));
            check($sformatf("vec%0d_rise", v), 32'(acc_rise), 32'(vecs[v].rise));
            check($sformatf("vec%0d_fall", v), 32'(acc_fall), 32'(vecs[v].fall));
        end

        // Bounce on bit 2: toggle every 5 cycles for 40 cycles, then hold high
        apply_reset();
        clear_acc();
        for (int seg = 0; seg < 8; seg++) begin
            raw_in[2] = (seg % 2 == 0);
            step(5);
        end
        check("bounce_no_rise", 32'(acc_rise), 32'h0);
        check("bounce_no_fall", 32'(acc_fall), 32'h0);
        check("bounce_no_clean", 32'(acc_clean), 32'h0);
        raw_in[2] = 1'b1;
        clear_acc();
        n_rise  = 0;
        rise_at = 0;
        for (int t = 1; t <= 30; t++) begin
            step(1);
            if (rise_pulse[2]) begin
                n_rise++;
                rise_at = t;
            end
        end
        check("bounce_rise_count", 32'(n_rise), 32'd1);
        check("bounce_rise_time", 32'(rise_at), 32'd18);
        check("bounce_clean", 32'(clean_out), 32'h4);
        check("bounce_fall", 32'(acc_fall), 32'h0);

        // Reset mid-count with an accepted level on bit 0 and a pending rise on bit 3
        apply_reset();
        raw_in = 4'b0001;
        step(18);
        check("rst_pre_clean", 32'(clean_out), 32'h1);
        raw_in = 4'b1001;
        step(10);
        #3;
        reset = 1'b1;
        #1;
        check("rst_async_clean", 32'(clean_out), 32'h0);
        check("rst_async_rise", 32'(rise_pulse), 32'h0);
        check("rst_async_fall", 32'(fall_pulse), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_acc();
        step(17);
        check("rst_quiet_clean", 32'(acc_clean), 32'h0);
        check("rst_quiet_rise", 32'(acc_rise), 32'h0);
        check("rst_quiet_fall", 32'(acc_fall), 32'h0);
        step(1);
        check("rst_accept_clean", 32'(clean_out), 32'h9);
        check("rst_accept_rise", 32'(rise_pulse), 32'h9);

        // DEBOUNCE_CYCLES=1, SYNC_STAGES=3: one sampled raw pulse
        apply_reset();
        raw2 = 1'b1;
        step(1);
        raw2 = 1'b0;
        step(2);
        check("fast_e3_clean", 32'(clean2), 32'h0);
        check("fast_e3_rise", 32'(rise2), 32'h0);
        step(1);
        check("fast_e4_clean", 32'(clean2), 32'h1);
        check("fast_e4_rise", 32'(rise2), 32'h1);
        check("fast_e4_fall", 32'(fall2), 32'h0);
        step(1);
        check("fast_e5_clean", 32'(clean2), 32'h0);
        check("fast_e5_rise", 32'(rise2), 32'h0);
        check("fast_e5_fall", 32'(fall2), 32'h1);
        step(1);
        check("fast_e6_fall", 32'(fall2), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_base_ext_debounce.md
Name: nios_base_ext_debounce

Overview:
- Input conditioning stage directly upstream of the ext_ctrl PIO. It drives that PIO's in_port.
- Takes WIDTH raw, asynchronous, bouncy external control lines (switches, board strobes).
- Per line: synchronises into clk, then filters with a consecutive-sample debounce counter. Outputs a clean level plus one-cycle rise/fall pulses.
- Because the clean level is glitch-free, the PIO's edge capture sees exactly one edge per real transition.

Parameters:
- WIDTH, 4, number of independent input lines.
- SYNC_STAGES, 2, synchroniser flop depth; legal range >= 2.
- DEBOUNCE_CYCLES, 16, consecutive stable synced samples required to accept a new level; legal range >= 1.
- CNT_W, clog2(DEBOUNCE_CYCLES+1), counter width; derived, not overridable.

Ports:
- clk  input  1  single clock domain.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  high = filtering active; low = outputs frozen.
- raw_in  input  WIDTH  asynchronous external lines.
- clean_out  output  WIDTH  debounced level; connects to PIO in_port.
- rise_pulse  output  WIDTH  one-cycle strobe on accepted 0->1.
- fall_pulse  output  WIDTH  one-cycle strobe on accepted 1->0.

Behaviour:
- Clocking/reset: one clock, clk. reset is asynchronous and active-high. Every flop clears on reset assertion.
- Reset values: all sync stages 0, all counters 0, clean_out 0, rise_pulse 0, fall_pulse 0.
- Channels are fully independent. There is no cross-channel state.
- Synchroniser: raw_in[i] passes through SYNC_STAGES flops to give s[i]. The chain always runs, regardless of enable.
- Per-channel counter cnt[i], evaluated each clock when enable=1:
  - s[i] == clean_out[i]: cnt <= 0.
  - s[i] != clean_out[i] and cnt < DEBOUNCE_CYCLES-1: cnt <= cnt+1.
  - s[i] != clean_out[i] and cnt == DEBOUNCE_CYCLES-1: clean_out[i] <= s[i] and cnt <= 0.
- Any sample equal to the current clean level restarts the count. Acceptance therefore requires DEBOUNCE_CYCLES consecutive differing synced samples.
- DEBOUNCE_CYCLES=1: clean_out follows s with one cycle of delay.
- Latency: a raw change that is stable from the sampling edge at cycle k appears on clean_out at cycle k+SYNC_STAGES+DEBOUNCE_CYCLES-1. Defaults give 17 cycles after the first sampling edge. Synchroniser uncertainty adds up to +1.
- Pulses:
  - rise_pulse[i]/fall_pulse[i] are registered and assert in the same cycle clean_out[i] first shows the new level.
  - Width is exactly one cycle.
  - They are never both high on one channel.
  - Minimum spacing between pulses on one channel is DEBOUNCE_CYCLES cycles.
- enable=0:
  - cnt held at 0, clean_out holds, pulses forced 0.
  - After enable returns to 1, a pending difference needs a full DEBOUNCE_CYCLES run.
- Reset mid-count: cnt, clean_out and the sync chain clear immediately. No pulse is issued on reset deassertion, even if raw_in is high. A high input is accepted as a normal rise after the full latency.
- Multiple channels may accept in the same cycle. Pulses then assert together on each affected bit.

Decomposition:
- Shared package nios_base_ext_pkg holds:
  - clog2 function;
  - default constants EXT_WIDTH=4, EXT_SYNC_STAGES=2, EXT_DEBOUNCE_CYCLES=16;
  - no typedefs needed.
- One sub-module, nios_base_ext_debounce_chan: single-bit synchroniser + counter + pulse logic.
- The top level generates WIDTH instances and concatenates their outputs.

Test Plan:
- Clean step, defaults: raw_in[0] 0->1 and held -> clean_out[0]=1 at cycle 17 (+1) after the first sampling edge. rise_pulse[0] high exactly 1 cycle in that same cycle. Other bits stay 0.
- Glitch rejection: raw_in[1] high for 15 cycles then low -> clean_out[1] stays 0, no pulses. Repeat with 16-cycle high -> accepted. Then 1->0 held -> fall_pulse[1] one cycle.
- Bounce: raw_in[2] toggles every 5 cycles for 40 cycles, then stays 1 -> exactly one rise_pulse[2], arriving 17 (+1) cycles after the final raw transition. No intermediate clean_out changes.
- Reset mid-count: raw_in[3]=1 for 10 cycles, assert reset asynchronously (between edges) -> clean_out and pulses 0 immediately. Deassert with raw_in[3] still 1 -> rise after a full 17 (+1) cycles, no pulse at deassertion.
- Enable freeze: clean_out=4'b0001. Drop enable, drive raw_in=4'b1110 for 30 cycles -> clean_out unchanged, no pulses. Raise enable -> clean_out=4'b1110 after DEBOUNCE_CYCLES cycles. rise_pulse=4'b1110 and fall_pulse=4'b0001 in the same cycle.
- Parameter corner DEBOUNCE_CYCLES=1, SYNC_STAGES=3: single-cycle raw pulse that is sampled -> clean_out pulses high for 1 cycle, 3 cycles after sampling. rise and fall pulses on consecutive cycles.
